instruction_packer: RTL and testbench
=====================================

# instruction_packer

Parametrised successor to the line-oriented assembler core. It consumes a pre-tokenised stream (mnemonic, register, immediate and resolved label-offset tokens) over a valid/ready handshake and validates operand order and count per RV32I format. It range-checks immediates and offsets, encodes the 32-bit instruction, and queues it with its PC in an output FIFO behind a second valid/ready handshake. Malformed lines are dropped with a coded, line-tagged error, and the rest of the line is flushed.

## Interface
- NUMBER_LINES, 256, lines per program; sets line and PC widths (LW = $clog2(NUMBER_LINES)).
- FIFO_DEPTH, 4, output queue entries; power of two, ≥ 2.
- CHECK_RANGE, 1, 1 enables immediate/offset range and alignment checks; 0 truncates silently.
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  synchronous, active-low reset.
- tok_valid_in  input  1  token present.
- tok_ready_out  output  1  token accepted when valid & ready.
- tok_type_in  input  3  0 MNEM, 1 REG, 2 IMM, 3 OFFSET, 7 BLANK; others illegal.
- tok_data_in  input  32  MNEM: [6:0] opcode, [9:7] funct3, [16:10] funct7. REG: [4:0]. IMM/OFFSET: signed 32-bit.
- tok_eol_in  input  1  token is the last of its source line.
- out_valid_out  output  1  FIFO head valid.
- out_ready_in  input  1  consumer pops head when valid & ready.
- out_inst_out  output  32  encoded instruction at head.
- out_pc_out  output  LW+2  byte PC of head.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  occupancy.
- err_out  output  1  one-cycle pulse per dropped line.
- err_code_out  output  3  1 bad opcode, 2 wrong token type, 3 missing operand, 4 extra operand, 5 out of range, 6 misaligned offset; held until the next error.
- err_line_out  output  LW  line index of the last error; held.

## Operation
- States: IDLE (expects MNEM or BLANK), OPERANDS (expects operand k), EMIT, FLUSH.
- Operand order per opcode:
  - REG 0110011: rd, rs1, rs2.
  - IMM 0010011, LOAD 0000011, JALR 1100111: rd, rs1, IMM.
  - STORE 0100011: rs2, rs1, IMM.
  - BRANCH 1100011: rs1, rs2, OFFSET.
  - LUI 0110111, AUIPC 0010111: rd, IMM.
  - JAL 1101111: rd, OFFSET.
- IDLE transitions:
  - MNEM with a listed opcode: latch funct fields, go to OPERANDS with k=0.
  - Unlisted opcode: error 1.
  - BLANK: consumed, no output.
  - REG, IMM or OFFSET in IDLE: error 2.
- OPERANDS transitions:
  - Wrong type: error 2.
  - eol before the last operand: error 3.
  - Last operand without eol: error 4.
  - Last operand with eol: range check, then EMIT.
- Range rules (CHECK_RANGE=1):
  - I/S/JALR: −2048..2047.
  - OP_IMM with funct3 001/101: shamt 0..31, and imm[11:5] = latched funct7.
  - B: −4096..4094. J: −1048576..1048574. An odd B/J offset gives error 6.
  - U: value fits 20 bits, signed or unsigned; placed in [31:12].
- Encoding is standard RV32I. The R-type funct7 comes from the MNEM token.
- Error handling:
  - Pulse err_out and latch the code and line.
  - If the offending token carried eol, go to IDLE; otherwise go to FLUSH, which discards tokens up to and including the next eol token, then goes to IDLE.
- Line counter:
  - +1 on every accepted eol token, including errored and BLANK lines.
  - Wraps to 0 after NUMBER_LINES−1.
- PC: +4 per instruction pushed. Dropped and blank lines do not advance the PC. Wraps modulo 2^(LW+2).
- FIFO:
  - Circular buffer.
  - A push when full is allowed only with a simultaneous pop.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop when empty is ignored.

## Timing
- Reset (rst_in=0 at an edge): state IDLE, FIFO empty, PC 0, line 0, all outputs 0, including tok_ready_out. tok_ready_out is 1 in the first cycle after release.
- tok_ready_out is 1 in IDLE, OPERANDS and FLUSH, and 0 in EMIT.
- At most one token is accepted per cycle.
- EMIT:
  - Lasts 1 cycle when the FIFO is not full, or when full with out_ready_in=1.
  - Otherwise it stalls until space is available.
  - On exit it returns to IDLE.
- Latency: final token accepted at edge N; FIFO written at edge N+1; out_valid_out=1 in the cycle after edge N+1 (empty FIFO, no stall).
- Throughput: one instruction per (operand tokens + 2) cycles.
- err_out is high for the one cycle after the edge that accepts the offending token. Code and line update at that same edge.
- Mid-operation reset: the partial line and FIFO contents are discarded, with no error pulse.

## Test plan
- Basic R-type: MNEM{0110011,f3 0,f7 0}, REG 1, REG 2, REG 3+eol → out_inst 0x003100B3, out_pc 0. Then addi x5,x0,−1 → 0xFFF00293, pc 4.
- Branch and shift: beq x1,x2,OFFSET −8 → 0xFE208CE3. srai x1,x1,3 (f3 101, f7 0100000) → 0x4030D093.
- Range error: addi x1,x0,IMM 2048 → err_out pulse, code 5, line 0, nothing queued. The next valid line is emitted with pc 0, line counter at 2.
- Wrong type with flush: MNEM add, REG 1, IMM 4 (no eol), REG 3+eol → code 2. The REG 3 token is discarded. BLANK+eol → no output, line +1.
- Backpressure: FIFO_DEPTH=2, out_ready_in=0, three add lines → third EMIT holds, tok_ready_out=0. Pulse out_ready_in once → simultaneous pop/push, fifo_count stays 2, pcs dequeue 0, 4, 8 in order.
- Reset mid-line: after MNEM and REG 1, assert rst_in=0 for 1 cycle → FIFO empty, outputs 0. A new full line is encoded at pc 0.

Source files
------------

// File: rtl/instruction_packer.sv
// instruction_packer: checks tokenised RV32I source lines, encodes them
// and queues each instruction with its byte PC behind a valid/ready FIFO.
module instruction_packer #(
    parameter int NUMBER_LINES = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int CHECK_RANGE  = 1,
    localparam int LW = $clog2(NUMBER_LINES),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          tok_valid_in,
    output logic          tok_ready_out,
    input  logic [2:0]    tok_type_in,
    input  logic [31:0]   tok_data_in,
    input  logic          tok_eol_in,
    output logic          out_valid_out,
    input  logic          out_ready_in,
    output logic [31:0]   out_inst_out,
    output logic [LW+1:0] out_pc_out,
    output logic [AW:0]   fifo_count_out,
    output logic          err_out,
    output logic [2:0]    err_code_out,
    output logic [LW-1:0] err_line_out
);

    localparam logic [2:0] T_MNEM  = 3'd0;
    localparam logic [2:0] T_REG   = 3'd1;
    localparam logic [2:0] T_IMM   = 3'd2;
    localparam logic [2:0] T_OFF   = 3'd3;
    localparam logic [2:0] T_BLANK = 3'd7;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] LAST_LINE = LW'(NUMBER_LINES - 1);

    typedef enum logic [1:0] {S_IDLE, S_OPER, S_EMIT, S_FLUSH} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J} fmt_t;

    state_t state_q, state_d;
    fmt_t   fmt_q, dec_fmt;
    logic   dec_ok;

    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic [6:0] f7_q;
    logic [1:0] k_q;
    logic [4:0] r0_q, r1_q;
    logic [31:0] inst_q;
    logic [LW+1:0] pc_q;
    logic [LW-1:0] line_q;
    logic alive_q;
    logic err_q;
    logic [2:0] code_q;
    logic [LW-1:0] eline_q;

    logic [31:0] inst_mem [FIFO_DEPTH];
    logic [LW+1:0] pc_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count_q;

    logic accept, full, push, pop;
    logic [1:0] last_k;
    logic [2:0] want;
    logic is_shift, range_ok, odd_off;
    logic [31:0] enc;
    logic signed [31:0] imm_s;

    logic err_set, mnem_ld, opnd_ld, inst_ld;
    logic [2:0] code_d;

    assign imm_s          = tok_data_in;
    assign tok_ready_out  = alive_q && (state_q != S_EMIT);
    assign accept         = tok_valid_in && tok_ready_out;
    assign full           = (count_q == DEPTH_C);
    assign out_valid_out  = (count_q != '0);
    assign push           = (state_q == S_EMIT) && (!full || out_ready_in);
    assign pop            = out_ready_in && out_valid_out;
    assign out_inst_out   = out_valid_out ? inst_mem[rd_ptr] : '0;
    assign out_pc_out     = out_valid_out ? pc_mem[rd_ptr] : '0;
    assign fifo_count_out = count_q;
    assign err_out        = err_q;
    assign err_code_out   = code_q;
    assign err_line_out   = eline_q;

    // Classify the opcode carried by an incoming MNEM token.
    always_comb begin
        dec_ok  = 1'b1;
        dec_fmt = F_R;
        case (tok_data_in[6:0])
            7'b0110011: dec_fmt = F_R;
            7'b0010011,
            7'b0000011,
            7'b1100111: dec_fmt = F_I;
            7'b0100011: dec_fmt = F_S;
            7'b1100011: dec_fmt = F_B;
            7'b0110111,
            7'b0010111: dec_fmt = F_U;
            7'b1101111: dec_fmt = F_J;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // Expected operand type, range/alignment tests and final encoding.
    always_comb begin
        last_k   = (fmt_q == F_U || fmt_q == F_J) ? 2'd1 : 2'd2;
        is_shift = (fmt_q == F_I) && (op_q == 7'b0010011)
                   && (f3_q == 3'b001 || f3_q == 3'b101);
        want     = T_REG;
        if (k_q == last_k) begin
            case (fmt_q)
                F_R:      want = T_REG;
                F_B, F_J: want = T_OFF;
                default:  want = T_IMM;
            endcase
        end
        range_ok = 1'b1;
        odd_off  = 1'b0;
        case (fmt_q)
            F_I, F_S: range_ok = is_shift ? (imm_s >= 0 && imm_s <= 31)
                                          : (imm_s >= -2048 && imm_s <= 2047);
            F_B: range_ok = (imm_s >= -4096 && imm_s <= 4094);
            F_J: range_ok = (imm_s >= -1048576 && imm_s <= 1048574);
            F_U: range_ok = (imm_s >= -524288 && imm_s <= 1048575);
            default: range_ok = 1'b1;
        endcase
        if (fmt_q == F_B || fmt_q == F_J) odd_off = tok_data_in[0];
        case (fmt_q)
            F_R: enc = {f7_q, tok_data_in[4:0], r1_q, f3_q, r0_q, op_q};
            F_I: enc = {is_shift ? {f7_q, tok_data_in[4:0]} : tok_data_in[11:0],
                        r1_q, f3_q, r0_q, op_q};
            F_S: enc = {tok_data_in[11:5], r0_q, r1_q, f3_q,
                        tok_data_in[4:0], op_q};
            F_B: enc = {tok_data_in[12], tok_data_in[10:5], r1_q, r0_q, f3_q,
                        tok_data_in[4:1], tok_data_in[11], op_q};
            F_U: enc = {tok_data_in[19:0], r0_q, op_q};
            F_J: enc = {tok_data_in[20], tok_data_in[10:1], tok_data_in[11],
                        tok_data_in[19:12], r0_q, op_q};
            default: enc = '0;
        endcase
    end

    // Line parser: next state and the error/latch strobes.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        code_d  = 3'd0;
        mnem_ld = 1'b0;
        opnd_ld = 1'b0;
        inst_ld = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (tok_type_in == T_MNEM) begin
                        if (!dec_ok) begin
                            err_set = 1'b1;
                            code_d  = 3'd1;
                        end else if (tok_eol_in) begin
                            err_set = 1'b1;
                            code_d  = 3'd3;
                        end else begin
                            mnem_ld = 1'b1;
                            state_d = S_OPER;
                        end
                    end else if (tok_type_in != T_BLANK) begin
                        err_set = 1'b1;
                        code_d  = 3'd2;
                    end
                end
            end
            S_OPER: begin
                if (accept) begin
                    if (tok_type_in != want) begin
                        err_set = 1'b1;
                        code_d  = 3'd2;
                    end else if (k_q != last_k) begin
                        if (tok_eol_in) begin
                            err_set = 1'b1;
                            code_d  = 3'd3;
                        end else begin
                            opnd_ld = 1'b1;
                        end
                    end else if (!tok_eol_in) begin
                        err_set = 1'b1;
                        code_d  = 3'd4;
                    end else if (CHECK_RANGE != 0 && !range_ok) begin
                        err_set = 1'b1;
                        code_d  = 3'd5;
                    end else if (CHECK_RANGE != 0 && odd_off) begin
                        err_set = 1'b1;
                        code_d  = 3'd6;
                    end else begin
                        inst_ld = 1'b1;
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (push) state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (accept && tok_eol_in) state_d = S_IDLE;
            end
        endcase
        if (err_set) state_d = tok_eol_in ? S_IDLE : S_FLUSH;
    end

    // Parser state, latched fields, line/PC counters and error report.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            alive_q <= 1'b0;
            fmt_q   <= F_R;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            k_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            inst_q  <= '0;
            pc_q    <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            eline_q <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            err_q   <= err_set;
            if (err_set) begin
                code_q  <= code_d;
                eline_q <= line_q;
            end
            if (mnem_ld) begin
                fmt_q <= dec_fmt;
                op_q  <= tok_data_in[6:0];
                f3_q  <= tok_data_in[9:7];
                f7_q  <= tok_data_in[16:10];
                k_q   <= '0;
            end else if (opnd_ld) begin
                if (k_q == 2'd0) r0_q <= tok_data_in[4:0];
                else             r1_q <= tok_data_in[4:0];
                k_q <= k_q + 2'd1;
            end
            if (inst_ld) inst_q <= enc;
            if (push) pc_q <= pc_q + (LW+2)'(4);
            if (accept && tok_eol_in)
                line_q <= (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
        end
    end

    // Output queue storage; contents are don't-care until counted valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[wr_ptr] <= inst_q;
            pc_mem[wr_ptr]   <= pc_q;
        end
    end

    // Output queue pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_packer.sv
// tb_instruction_packer: directed and random lines against a line-level
// reference model; pops and error pulses are matched against its queues.
module tb_instruction_packer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        tok_valid_in = 1'b0;
    logic        tok_ready_out;
    logic [2:0]  tok_type_in = 3'd0;
    logic [31:0] tok_data_in = 32'd0;
    logic        tok_eol_in = 1'b0;
    logic        out_valid_out;
    logic        out_ready_in = 1'b0;
    logic [31:0] out_inst_out;
    logic [9:0]  out_pc_out;
    logic [1:0]  fifo_count_out;
    logic        err_out;
    logic [2:0]  err_code_out;
    logic [7:0]  err_line_out;

    always #5 clk_in = ~clk_in;

    instruction_packer #(
        .NUMBER_LINES(256),
        .FIFO_DEPTH(2),
        .CHECK_RANGE(1)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tok_valid_in(tok_valid_in),
        .tok_ready_out(tok_ready_out),
        .tok_type_in(tok_type_in),
        .tok_data_in(tok_data_in),
        .tok_eol_in(tok_eol_in),
        .out_valid_out(out_valid_out),
        .out_ready_in(out_ready_in),
        .out_inst_out(out_inst_out),
        .out_pc_out(out_pc_out),
        .fifo_count_out(fifo_count_out),
        .err_out(err_out),
        .err_code_out(err_code_out),
        .err_line_out(err_line_out)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit rand_rdy = 0;

    int lt[16];
    logic [31:0] ld[16];
    int ln;

    logic [31:0] exp_inst[$];
    logic [9:0]  exp_pc[$];
    logic [2:0]  exp_code[$];
    logic [7:0]  exp_line[$];
    logic [9:0]  m_pc;
    logic [7:0]  m_line;

    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F};
    int edges[21] = '{-1048577, -1048576, -524289, -524288, -4097, -4096,
                      -4095, -2049, -2048, -1, 0, 1, 31, 32, 2047, 2048,
                      4094, 4095, 1048574, 1048575, 1048576};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mnem(input logic [6:0] op,
                                         input logic [2:0] f3,
                                         input logic [6:0] f7);
        return {15'd0, f7, f3, op};
    endfunction

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'h33: return 0;
            7'h13, 7'h03, 7'h67: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic int pick_imm();
        int s;
        s = int'($urandom_range(0, 3));
        if (s == 0) return edges[$urandom_range(0, 20)];
        if (s == 1) return int'($urandom_range(0, 31));
        if (s == 2) return int'($urandom_range(0, 8191)) - 4096;
        return int'($urandom);
    endfunction

    task automatic new_line();
        ln = 0;
    endtask

    task automatic add_tok(input int t, input logic [31:0] d);
        lt[ln] = t;
        ld[ln] = d;
        ln++;
    endtask

    // Reference model: outcome of one whole line, eol on its last token.
    task automatic model_line();
        int code, kind, nops, want, v;
        bit blank, ok, shift;
        logic [31:0] op, f3, f7, a, b, c, vv, inst;
        code = 0;
        blank = 0;
        inst = 0;
        op = {25'd0, ld[0][6:0]};
        f3 = {29'd0, ld[0][9:7]};
        f7 = {25'd0, ld[0][16:10]};
        kind = kind_of(ld[0][6:0]);
        if (lt[0] == 7) blank = 1;
        else if (lt[0] != 0) code = 2;
        else if (kind < 0) code = 1;
        else if (ln == 1) code = 3;
        else begin
            nops = (kind >= 4) ? 2 : 3;
            for (int i = 0; i < nops && code == 0; i++) begin
                if (i < nops - 1 || kind == 0) want = 1;
                else if (kind == 3 || kind == 5) want = 3;
                else want = 2;
                if (lt[i+1] != want) code = 2;
                else if (i < nops - 1 && i + 1 == ln - 1) code = 3;
                else if (i == nops - 1 && i + 1 != ln - 1) code = 4;
            end
            if (code == 0) begin
                v = int'(ld[nops]);
                vv = ld[nops];
                shift = (kind == 1) && (op == 32'h13) && (f3 == 1 || f3 == 5);
                case (kind)
                    1, 2: ok = shift ? (v >= 0 && v <= 31)
                                     : (v >= -2048 && v <= 2047);
                    3: ok = (v >= -4096 && v <= 4094);
                    4: ok = (v >= -524288 && v <= 1048575);
                    5: ok = (v >= -1048576 && v <= 1048574);
                    default: ok = 1;
                endcase
                if (!ok) code = 5;
                else if ((kind == 3 || kind == 5) && (v % 2 != 0)) code = 6;
                a = ld[1] & 31;
                b = ld[2] & 31;
                c = ld[3] & 31;
                case (kind)
                    0: inst = (f7 << 25) | (c << 20) | (b << 15) | (f3 << 12)
                              | (a << 7) | op;
                    1: inst = ((shift ? ((f7 << 5) | (vv & 31)) : (vv & 32'hFFF)) << 20)
                              | (b << 15) | (f3 << 12) | (a << 7) | op;
                    2: inst = (((vv >> 5) & 32'h7F) << 25) | (a << 20) | (b << 15)
                              | (f3 << 12) | ((vv & 31) << 7) | op;
                    3: inst = (((vv >> 12) & 1) << 31) | (((vv >> 5) & 63) << 25)
                              | (b << 20) | (a << 15) | (f3 << 12)
                              | (((vv >> 1) & 15) << 8) | (((vv >> 11) & 1) << 7) | op;
                    4: inst = ((vv & 32'hFFFFF) << 12) | (a << 7) | op;
                    default: inst = (((vv >> 20) & 1) << 31)
                              | (((vv >> 1) & 32'h3FF) << 21)
                              | (((vv >> 11) & 1) << 20)
                              | (((vv >> 12) & 32'hFF) << 12) | (a << 7) | op;
                endcase
            end
        end
        if (!blank && code != 0) begin
            exp_code.push_back(3'(code));
            exp_line.push_back(m_line);
        end else if (!blank) begin
            exp_inst.push_back(inst);
            exp_pc.push_back(m_pc);
            m_pc = m_pc + 10'd4;
        end
        m_line = m_line + 8'd1;
    endtask

    task automatic send_tok(input int t, input logic [31:0] d, input bit eol);
        int n;
        n = 0;
        tok_valid_in = 1'b1;
        tok_type_in = 3'(t);
        tok_data_in = d;
        tok_eol_in = eol;
        if (rand_rdy) out_ready_in = ($urandom_range(0, 3) != 0);
        while (!tok_ready_out && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
            if (rand_rdy) out_ready_in = ($urandom_range(0, 3) != 0);
        end
        if (n >= 100) check("tok_ready_timeout", 32'(tok_ready_out), 32'd1);
        @(posedge clk_in);
        #1;
        tok_valid_in = 1'b0;
        tok_eol_in = 1'b0;
    endtask

    task automatic run_line();
        model_line();
        for (int i = 0; i < ln; i++) send_tok(lt[i], ld[i], i == ln - 1);
    endtask

    task automatic do_reset();
        tok_valid_in = 1'b0;
        tok_eol_in = 1'b0;
        out_ready_in = 1'b0;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        exp_inst.delete();
        exp_pc.delete();
        exp_code.delete();
        exp_line.delete();
        m_pc = '0;
        m_line = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pop_one();
        out_ready_in = 1'b1;
        tick();
        out_ready_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready_in = 1'b1;
        while (out_valid_out && n < 50) begin
            tick();
            n++;
        end
        out_ready_in = 1'b0;
        check("drain_empty", 32'(fifo_count_out), 32'd0);
    endtask

    task automatic line_add(input int rd, input int rs1, input int rs2);
        new_line();
        add_tok(0, mnem(7'h33, 3'd0, 7'd0));
        add_tok(1, rd);
        add_tok(1, rs1);
        add_tok(1, rs2);
    endtask

    task automatic line_addi(input int rd, input int rs1, input int imm);
        new_line();
        add_tok(0, mnem(7'h13, 3'd0, 7'd0));
        add_tok(1, rd);
        add_tok(1, rs1);
        add_tok(2, imm);
    endtask

    // Scoreboard: every pop and every error pulse must match the model.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (out_valid_out && out_ready_in) begin
                if (exp_inst.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    check("pop_inst", out_inst_out, exp_inst.pop_front());
                    check("pop_pc", 32'(out_pc_out), 32'(exp_pc.pop_front()));
                end
            end
            if (err_out) begin
                if (exp_code.size() == 0) begin
                    check("err_unexpected", 32'd1, 32'd0);
                end else begin
                    check("err_code", 32'(err_code_out), 32'(exp_code.pop_front()));
                    check("err_line", 32'(err_line_out), 32'(exp_line.pop_front()));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_ready", 32'(tok_ready_out), 32'd0);
        check("rst_valid", 32'(out_valid_out), 32'd0);
        check("rst_count", 32'(fifo_count_out), 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        check("rst_code", 32'(err_code_out), 32'd0);
        check("rst_line", 32'(err_line_out), 32'd0);
        check("rst_inst", out_inst_out, 32'd0);
        check("rst_pc", 32'(out_pc_out), 32'd0);
        tick();
        check("ready_after_rst", 32'(tok_ready_out), 32'd1);

        line_add(1, 2, 3);
        run_line();
        check("lat_not_yet", 32'(out_valid_out), 32'd0);
        check("emit_not_ready", 32'(tok_ready_out), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid_out), 32'd1);
        check("add_inst", out_inst_out, 32'h003100B3);
        check("add_pc", 32'(out_pc_out), 32'd0);
        check("ready_back", 32'(tok_ready_out), 32'd1);

        line_addi(5, 0, -1);
        run_line();
        tick();
        check("count_two", 32'(fifo_count_out), 32'd2);
        pop_one();
        check("addi_inst", out_inst_out, 32'hFFF00293);
        check("addi_pc", 32'(out_pc_out), 32'd4);
        pop_one();

        new_line();
        add_tok(0, mnem(7'h63, 3'd0, 7'd0));
        add_tok(1, 1);
        add_tok(1, 2);
        add_tok(3, -8);
        run_line();
        tick();
        check("beq_inst", out_inst_out, 32'hFE208CE3);
        check("beq_pc", 32'(out_pc_out), 32'd8);
        pop_one();

        new_line();
        add_tok(0, mnem(7'h13, 3'b101, 7'b0100000));
        add_tok(1, 1);
        add_tok(1, 1);
        add_tok(2, 3);
        run_line();
        tick();
        check("srai_inst", out_inst_out, 32'h4030D093);
        check("srai_pc", 32'(out_pc_out), 32'd12);
        pop_one();

        do_reset();
        tick();
        line_addi(1, 0, 2048);
        run_line();
        check("range_pulse", 32'(err_out), 32'd1);
        check("range_code", 32'(err_code_out), 32'd5);
        check("range_line", 32'(err_line_out), 32'd0);
        check("range_nothing", 32'(fifo_count_out), 32'd0);
        tick();
        check("pulse_one_cycle", 32'(err_out), 32'd0);
        line_add(4, 5, 6);
        run_line();
        tick();
        check("after_err_pc", 32'(out_pc_out), 32'd0);
        pop_one();
        new_line();
        add_tok(0, mnem(7'h7F, 3'd0, 7'd0));
        run_line();
        check("badop_code", 32'(err_code_out), 32'd1);
        check("badop_line", 32'(err_line_out), 32'd2);

        new_line();
        add_tok(0, mnem(7'h33, 3'd0, 7'd0));
        add_tok(1, 1);
        add_tok(2, 4);
        add_tok(1, 3);
        run_line();
        check("flush_code", 32'(err_code_out), 32'd2);
        check("flush_line", 32'(err_line_out), 32'd3);
        check("flush_idle", 32'(tok_ready_out), 32'd1);
        check("flush_nothing", 32'(fifo_count_out), 32'd0);
        new_line();
        add_tok(7, 0);
        run_line();
        new_line();
        add_tok(0, mnem(7'h00, 3'd0, 7'd0));
        run_line();
        check("blank_line_count", 32'(err_line_out), 32'd5);

        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            line_add(1, 2, 3);
            run_line();
        end
        tick();
        tick();
        tick();
        check("stall_not_ready", 32'(tok_ready_out), 32'd0);
        check("stall_count", 32'(fifo_count_out), 32'd2);
        check("stall_head_pc", 32'(out_pc_out), 32'd0);
        pop_one();
        check("popush_count", 32'(fifo_count_out), 32'd2);
        check("popush_ready", 32'(tok_ready_out), 32'd1);
        check("popush_head_pc", 32'(out_pc_out), 32'd4);
        drain();

        line_add(7, 8, 9);
        run_line();
        send_tok(0, mnem(7'h33, 3'd0, 7'd0), 1'b0);
        send_tok(1, 1, 1'b0);
        do_reset();
        check("midrst_count", 32'(fifo_count_out), 32'd0);
        check("midrst_valid", 32'(out_valid_out), 32'd0);
        check("midrst_err", 32'(err_out), 32'd0);
        check("midrst_ready", 32'(tok_ready_out), 32'd0);
        tick();
        line_addi(5, 0, -1);
        run_line();
        tick();
        check("midrst_inst", out_inst_out, 32'hFFF00293);
        check("midrst_pc", 32'(out_pc_out), 32'd0);
        drain();

        rand_rdy = 1;
        for (int l = 0; l < 120; l++) begin
            int r, r2, nops;
            logic [6:0] op;
            logic [2:0] f3;
            logic [6:0] f7;
            new_line();
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                add_tok(7, 0);
            end else begin
                op = ops[$urandom_range(0, 8)];
                if (r == 1) op = 7'($urandom);
                f3 = 3'($urandom);
                f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom);
                if ($urandom_range(0, 3) == 0) f7 = 7'd0;
                nops = (op == 7'h37 || op == 7'h17 || op == 7'h6F) ? 2 : 3;
                add_tok(0, mnem(op, f3, f7));
                for (int i = 0; i < nops - 1; i++) add_tok(1, $urandom);
                if (op == 7'h33) add_tok(1, $urandom);
                else add_tok((op == 7'h63 || op == 7'h6F) ? 3 : 2, pick_imm());
                r2 = int'($urandom_range(0, 9));
                if (r2 == 0) ln--;
                else if (r2 == 1) add_tok(1, $urandom);
                else if (r2 == 2) lt[$urandom_range(1, ln - 1)] = int'($urandom_range(1, 7));
                else if (r2 == 3) lt[0] = int'($urandom_range(1, 3));
            end
            run_line();
        end
        rand_rdy = 0;
        tick();
        tick();
        drain();
        tick();
        tick();
        check("left_inst", 32'(exp_inst.size()), 32'd0);
        check("left_err", 32'(exp_code.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
